// File: rtl/regfile_mp.sv
// regfile_mp: multi-port general-purpose register file with a per-register
// pending scoreboard.
//   - two synchronous write ports (port 1 wins on an address collision)
//   - two asynchronous read ports that return data and a pending (busy) flag
//   - one asynchronous debug read port (test_data)
//   - claim port that marks a destination register pending at issue
//   - registered pend_cnt, which is the number of pending registers,
//     maintained incrementally
// Register 0 reads as zero and is never pending. Writes and claims to it are
// dropped.
// Build option: define RF_BYPASS_EN to forward same-cycle write data and
// pending state onto rdata1/rdata2/rbusy1/rbusy2. test_data is never
// forwarded.

module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    // decode/issue read ports
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rbusy1,
    output logic              rbusy2,
    // write-back ports
    input  logic              wen0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              wen1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    // scoreboard claim at issue
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic [ADDR_W:0]   pend_cnt,
    // debug read port
    input  logic [ADDR_W-1:0] test_addr,
    output logic [DATA_W-1:0] test_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    // Architectural state
    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:0]  pending;

    // Qualified requests. Anything aimed at register 0 is dropped here, so
    // none of the logic below needs a separate check for register 0.
    logic wr0_act;
    logic wr1_act;
    logic cl_act;

    assign wr0_act = wen0 && (waddr0 != '0);
    assign wr1_act = wen1 && (waddr1 != '0);
    assign cl_act  = claim_en && (claim_addr != '0);

    // Scoreboard bookkeeping for pend_cnt
    logic             claim_inc;  // the claim sets a bit that was clear
    logic             clr0;       // port 0 clears a set bit
    logic             clr1;       // port 1 clears a set bit that port 0 does not also clear
    logic [CNT_W-1:0] cnt_nxt;
    logic [DEPTH-1:0] pend_nxt;

    // Register array write. Port 1 is assigned last, so it wins on a shared address.
    // NOTE: the whole array is reset because the register file must read as
    // zero immediately during reset. This rules out mapping rf onto RAM macros.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (wr0_act) begin
                rf[waddr0] <= wdata0;
            end
            if (wr1_act) begin
                rf[waddr1] <= wdata1;
            end
        end
    end

    // Next pending vector. A write-back clears the bit. A claim in the same
    // cycle sets it again, because the new owner takes precedence.
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first. Any path that leaves a variable unassigned infers a latch.
    always_comb begin
        pend_nxt = pending;
        if (wr0_act) begin
            pend_nxt[waddr0] = 1'b0;
        end
        if (wr1_act) begin
            pend_nxt[waddr1] = 1'b0;
        end
        if (cl_act) begin
            pend_nxt[claim_addr] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // Incremental pend_cnt update. Each event is counted only when it changes
    // a bit. If a claim and a write hit the same pending register, the net
    // change is zero.
    always_comb begin
        claim_inc = cl_act && !pending[claim_addr];
        clr0      = wr0_act && pending[waddr0]
                    && !(cl_act && (claim_addr == waddr0));
        clr1      = wr1_act && pending[waddr1]
                    && !(cl_act && (claim_addr == waddr1))
                    && !(wr0_act && (waddr0 == waddr1));
        cnt_nxt   = pend_cnt + CNT_W'(claim_inc) - CNT_W'(clr0) - CNT_W'(clr1);
    end

    // Scoreboard state and pending-count register.
    // NOTE: sequential state is updated only with non-blocking '<='. All flops
    // then sample values from before the edge, whatever the block order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    // Read port 1: stored data and pending flag, optionally forwarded from write-back
    always_comb begin
        rdata1 = '0;
        rbusy1 = 1'b0;
        if (raddr1 != '0) begin
            rdata1 = rf[raddr1];
            rbusy1 = pending[raddr1];
`ifdef RF_BYPASS_EN
            if (resetn) begin
                if (wr1_act && (waddr1 == raddr1)) begin
                    rdata1 = wdata1;
                    rbusy1 = cl_act && (claim_addr == raddr1);
                end else if (wr0_act && (waddr0 == raddr1)) begin
                    rdata1 = wdata0;
                    rbusy1 = cl_act && (claim_addr == raddr1);
                end
            end
`endif
        end
    end

    // Read port 2: stored data and pending flag, optionally forwarded from write-back
    always_comb begin
        rdata2 = '0;
        rbusy2 = 1'b0;
        if (raddr2 != '0) begin
            rdata2 = rf[raddr2];
            rbusy2 = pending[raddr2];
`ifdef RF_BYPASS_EN
            if (resetn) begin
                if (wr1_act && (waddr1 == raddr2)) begin
                    rdata2 = wdata1;
                    rbusy2 = cl_act && (claim_addr == raddr2);
                end else if (wr0_act && (waddr0 == raddr2)) begin
                    rdata2 = wdata0;
                    rbusy2 = cl_act && (claim_addr == raddr2);
                end
            end
`endif
        end
    end

    // Debug port: stored state only, never forwarded
    always_comb begin
        test_data = '0;
        if (test_addr != '0) begin
            test_data = rf[test_addr];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp.
// Phases: reset state, mid-run asynchronous reset, table-driven directed
// vectors, same-cycle bypass sequence, and randomized traffic checked against
// an array-based reference model. Build with +define+RF_BYPASS_EN to test the
// forwarding variant.

module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk;
    logic              resetn;
    logic [ADDR_W-1:0] raddr1, raddr2, waddr0, waddr1, claim_addr, test_addr;
    logic [DATA_W-1:0] rdata1, rdata2, wdata0, wdata1, test_data;
    logic              rbusy1, rbusy2, wen0, wen1, claim_en;
    logic [ADDR_W:0]   pend_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .rbusy1     (rbusy1),
        .rbusy2     (rbusy2),
        .wen0       (wen0),
        .waddr0     (waddr0),
        .wdata0     (wdata0),
        .wen1       (wen1),
        .waddr1     (waddr1),
        .wdata1     (wdata1),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .pend_cnt   (pend_cnt),
        .test_addr  (test_addr),
        .test_data  (test_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_rf [DEPTH];
    bit               m_pend [DEPTH];

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_rf[i]   = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    // Apply one clock edge: writes in port order, then the claim wins on pending.
    task automatic model_edge();
        if (wen0 && waddr0 != 0) begin
            m_rf[waddr0]   = wdata0;
            m_pend[waddr0] = 1'b0;
        end
        if (wen1 && waddr1 != 0) begin
            m_rf[waddr1]   = wdata1;
            m_pend[waddr1] = 1'b0;
        end
        if (claim_en && claim_addr != 0) m_pend[claim_addr] = 1'b1;
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] model_rdata(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
`ifdef RF_BYPASS_EN
        if (wen1 && waddr1 == a) return wdata1;
        if (wen0 && waddr0 == a) return wdata0;
`endif
        return m_rf[a];
    endfunction

    function automatic logic model_rbusy(input logic [ADDR_W-1:0] a);
        if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        if ((wen1 && waddr1 == a) || (wen0 && waddr0 == a))
            return claim_en && claim_addr == a;
`endif
        return m_pend[a];
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic idle_inputs();
        wen0 = 0; wen1 = 0; claim_en = 0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; claim_addr = '0;
    endtask

    // One rising edge, model updated with the inputs the DUT sampled, then settle.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic              w0;
        logic [ADDR_W-1:0] a0;
        logic [DATA_W-1:0] d0;
        logic              w1;
        logic [ADDR_W-1:0] a1;
        logic [DATA_W-1:0] d1;
        logic              cl;
        logic [ADDR_W-1:0] ca;
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] e_data;
        logic              e_busy;
        logic [ADDR_W:0]   e_cnt;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic w0, input int a0, input int d0,
                                input logic w1, input int a1, input int d1,
                                input logic cl, input int ca, input int ra,
                                input int ed, input logic eb, input int ec);
        vec_t v;
        v.w0 = w0; v.a0 = ADDR_W'(a0); v.d0 = DATA_W'(d0);
        v.w1 = w1; v.a1 = ADDR_W'(a1); v.d1 = DATA_W'(d1);
        v.cl = cl; v.ca = ADDR_W'(ca); v.ra = ADDR_W'(ra);
        v.e_data = DATA_W'(ed); v.e_busy = eb; v.e_cnt = (ADDR_W+1)'(ec);
        return v;
    endfunction

    initial begin
        // Expected values are the state after the edge, read with idle write inputs.
        //            w0 a0  d0       w1 a1  d1      cl ca  ra  data     busy cnt
        vecs[0]  = mk(1, 3,  'hAAAA,  1, 3,  'h5555, 0, 0,  3,  'h5555, 0, 0); // dual-write collision
        vecs[1]  = mk(1, 0,  'hFFFF,  1, 0,  'h1,    0, 0,  0,  0,      0, 0); // writes to r0 ignored
        vecs[2]  = mk(0, 0,  0,       0, 0,  0,      1, 7,  7,  0,      1, 1); // claim r7
        vecs[3]  = mk(0, 0,  0,       0, 0,  0,      1, 8,  7,  0,      1, 2); // claim r8
        vecs[4]  = mk(1, 7,  'hBEEF,  0, 0,  0,      0, 0,  7,  'hBEEF, 0, 1); // write-back clears r7
        vecs[5]  = mk(0, 0,  0,       0, 0,  0,      1, 9,  9,  0,      1, 2); // claim r9
        vecs[6]  = mk(0, 0,  0,       1, 9,  'h77,   1, 9,  9,  'h77,   1, 2); // claim+write r9
        vecs[7]  = mk(0, 0,  0,       0, 0,  0,      1, 0,  0,  0,      0, 2); // claim r0 ignored
        vecs[8]  = mk(0, 0,  0,       0, 0,  0,      1, 10, 10, 0,      1, 3); // claim r10
        vecs[9]  = mk(0, 0,  0,       0, 0,  0,      1, 10, 10, 0,      1, 3); // re-claim pending r10
        vecs[10] = mk(1, 8,  'h1,     1, 10, 'h2,    0, 0,  10, 'h2,    0, 1); // two clears: -2
        vecs[11] = mk(1, 11, 'h11,    0, 0,  0,      0, 0,  11, 'h11,   0, 1); // write non-pending reg
        vecs[12] = mk(1, 9,  'h99,    1, 9,  'h55,   0, 0,  9,  'h55,   0, 0); // collision clears r9
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [ADDR_W-1:0] ra_r, rb_r, rt_r;

        idle_inputs();
        raddr1 = '0; raddr2 = '0; test_addr = '0;
        resetn = 1'b0;
        model_reset();

        // Reset state
        #12;
        raddr1 = 5'd3; raddr2 = 5'd4; test_addr = 5'd5;
        #1;
        check("reset_rdata1", rdata1, '0);
        check("reset_rbusy2", {31'd0, rbusy2}, '0);
        check("reset_pend_cnt", {26'd0, pend_cnt}, '0);
        check("reset_test_data", test_data, '0);
        @(negedge clk);
        resetn = 1'b1;

        // Mid-run asynchronous reset
        wen0 = 1; waddr0 = 5'd5; wdata0 = 32'h1234;
        claim_en = 1; claim_addr = 5'd6;
        tick();
        idle_inputs();
        raddr1 = 5'd5; raddr2 = 5'd6; test_addr = 5'd5;
        #1;
        check("pre_reset_rdata1", rdata1, 32'h1234);
        check("pre_reset_rbusy2", {31'd0, rbusy2}, 32'd1);
        check("pre_reset_pend_cnt", {26'd0, pend_cnt}, 32'd1);
        #1;
        resetn = 1'b0;
        model_reset();
        #1;
        check("midreset_rdata1", rdata1, '0);
        check("midreset_rbusy2", {31'd0, rbusy2}, '0);
        check("midreset_pend_cnt", {26'd0, pend_cnt}, '0);
        check("midreset_test_data", test_data, '0);
        #1;
        resetn = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            wen0 = vecs[i].w0; waddr0 = vecs[i].a0; wdata0 = vecs[i].d0;
            wen1 = vecs[i].w1; waddr1 = vecs[i].a1; wdata1 = vecs[i].d1;
            claim_en = vecs[i].cl; claim_addr = vecs[i].ca;
            tick();
            idle_inputs();
            raddr1 = vecs[i].ra; raddr2 = vecs[i].ra; test_addr = vecs[i].ra;
            #1;
            check($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].e_data);
            check($sformatf("vec%0d_rdata2", i), rdata2, vecs[i].e_data);
            check($sformatf("vec%0d_test_data", i), test_data, vecs[i].e_data);
            check($sformatf("vec%0d_rbusy1", i), {31'd0, rbusy1}, {31'd0, vecs[i].e_busy});
            check($sformatf("vec%0d_rbusy2", i), {31'd0, rbusy2}, {31'd0, vecs[i].e_busy});
            check($sformatf("vec%0d_pend_cnt", i), {26'd0, pend_cnt}, {26'd0, vecs[i].e_cnt});
        end

        // Same-cycle bypass: r4 has never been written, so its stored value is 0
        wen0 = 1; waddr0 = 5'd4; wdata0 = 32'hCAFE;
        raddr1 = 5'd4; test_addr = 5'd4;
        #1;
`ifdef RF_BYPASS_EN
        check("bypass_same_cycle", rdata1, 32'hCAFE);
`else
        check("bypass_same_cycle", rdata1, 32'h0);
`endif
        check("bypass_test_port", test_data, 32'h0);
        tick();
        idle_inputs();
        #1;
        check("bypass_next_cycle", rdata1, 32'hCAFE);

        // Randomized traffic against the model, checked mid-cycle with inputs active
        for (int n = 0; n < 400; n++) begin
            wen0 = 1'($urandom_range(0, 1));
            waddr0 = ADDR_W'($urandom_range(0, 15));
            wdata0 = $urandom;
            wen1 = 1'($urandom_range(0, 1));
            waddr1 = ADDR_W'($urandom_range(0, 15));
            wdata1 = $urandom;
            claim_en = 1'($urandom_range(0, 1));
            claim_addr = ADDR_W'($urandom_range(0, 15));
            ra_r = ADDR_W'($urandom_range(0, 15));
            rb_r = ($urandom_range(0, 3) == 0) ? waddr1 : ADDR_W'($urandom_range(0, 15));
            rt_r = ADDR_W'($urandom_range(0, 15));
            raddr1 = ra_r; raddr2 = rb_r; test_addr = rt_r;
            #1;
            check("rnd_rdata1", rdata1, model_rdata(ra_r));
            check("rnd_rdata2", rdata2, model_rdata(rb_r));
            check("rnd_rbusy1", {31'd0, rbusy1}, {31'd0, model_rbusy(ra_r)});
            check("rnd_rbusy2", {31'd0, rbusy2}, {31'd0, model_rbusy(rb_r)});
            check("rnd_test_data", test_data, (rt_r == 0) ? '0 : m_rf[rt_r]);
            check("rnd_pend_cnt", {26'd0, pend_cnt}, 32'(model_count()));
            tick();
        end
        idle_inputs();
        #1;
        check("final_pend_cnt", {26'd0, pend_cnt}, 32'(model_count()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file with a per-register pending scoreboard, successor to the single-write-port register file of the multi-cycle CPU. It has two synchronous write ports, two asynchronous read ports and one asynchronous debug/test read port. A claim port marks a destination register pending at issue; the pending mark clears when a write-back to that register lands. Sits between decode/issue (reads, claims) and write-back (writes).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W; register 0 hardwired to zero
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- raddr1, raddr2  in  ADDR_W  read port addresses
- rdata1, rdata2  out  DATA_W  read data, combinational
- rbusy1, rbusy2  out  1  pending flag of the addressed register, combinational
- wen0, wen1  in  1  write enables
- waddr0, waddr1  in  ADDR_W  write addresses
- wdata0, wdata1  in  DATA_W  write data
- claim_en  in  1  mark claim_addr pending
- claim_addr  in  ADDR_W  register to claim
- pend_cnt  out  ADDR_W+1  number of registers currently pending, registered
- test_addr  in  ADDR_W  debug read address
- test_data  out  DATA_W  debug read data, combinational

## Operation
- Reset (resetn low, any time, including mid-operation): all registers 0, all pending bits 0, pend_cnt 0. Effective immediately, not waiting for clk. Reads during reset return 0 with busy 0.
- Register 0: writes and claims to it are ignored. Reads of it return 0 with busy 0, on every read port and the test port.
- Write: on a rising edge with wenN=1 and waddrN≠0, rf[waddrN] ← wdataN and pending[waddrN] ← 0.
- Write to a register that is not pending is legal: data is written, pending stays 0.
- Both write ports to the same nonzero address in one cycle: port 1 data wins; pending cleared.
- Claim: on a rising edge with claim_en=1 and claim_addr≠0, pending[claim_addr] ← 1.
- Claim and write to the same register in the same cycle: the write's data lands and pending ends at 1 (the new owner's claim takes precedence over the old write-back).
- Claiming an already pending register: stays pending; pend_cnt unchanged.
- pend_cnt equals the popcount of pending[] after each edge, updated incrementally. Per-edge change ∈ {−2,−1,0,+1}. Range 0 … 2**ADDR_W−1, so no overflow.
- Reads are pure functions of the current state plus the bypass path (see Configuration). Reads never modify state.

## Timing
- Write latency: data is visible on non-bypassed reads in the cycle after the write edge.
- Claim latency: rbusyN rises in the cycle after the claim edge.
- Pending clear: without bypass, rbusyN falls in the cycle after the write edge.
- pend_cnt reflects the edge that has just occurred; it is never combinational from the inputs.
- No handshake back-pressure: every write and claim is accepted every cycle.

## Configuration
- RF_BYPASS_EN defined: same-cycle forwarding on rdata1/rdata2/rbusy1/rbusy2.
  - If a read address matches an active write address (≠0), rdata returns that wdata. If both write ports match, port 1 is forwarded.
  - rbusy returns 0 on a match, unless claim_en targets the same address.
  - test_data is never bypassed.
- RF_BYPASS_EN undefined: reads return stored state only, with the one-cycle latencies given above.

## Test plan
- Reset mid-run: write r5=0x1234, claim r6, then pulse resetn low between edges. Required: rdata(r5)=0, rbusy(r6)=0, pend_cnt=0 immediately.
- Dual write collision: wen0/wen1 to r3 with 0xAAAA/0x5555. Required: next cycle rdata1(r3)=0x5555. Separately, writes to r0 leave rdata(r0)=0.
- Scoreboard: claim r7, then r8 on consecutive edges. Required: pend_cnt 1 then 2, and rbusy(r7)=1. Then write r7=0xBEEF. Required: rbusy(r7)=0, pend_cnt=1, rdata=0xBEEF.
- Claim+write collision: r9 pending; in the same cycle claim r9 and write r9=0x77. Required: afterwards rdata=0x77, rbusy=1, pend_cnt unchanged.
- Bypass: write r4=0xCAFE while raddr1=4 in the same cycle. With RF_BYPASS_EN: rdata1=0xCAFE in that cycle. Without it: old value in that cycle, 0xCAFE the next.
- Claim r0 and claim an already-pending r10. Required: pend_cnt unchanged, rbusy(r0)=0.
